// File: rtl/tridiag_det_feeder.sv
// Feeder and sequencer for the tridiagonal determinant unit.
// Collects 3N-2 coefficient words (b, then a, then c) into the flat buses,
// starts the determinant unit, collects its result and offers it downstream.
module tridiag_det_feeder #(
  parameter int unsigned N     = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  // coefficient input stream
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     flush,
  // result output stream
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       out_det,
  output logic                     busy,
  // determinant unit interface
  output logic [WIDTH*(N-1)-1:0]   a_flat,
  output logic [WIDTH*N-1:0]       b_flat,
  output logic [WIDTH*(N-1)-1:0]   c_flat,
  output logic                     start,
  input  logic                     done,
  input  logic [2*WIDTH-1:0]       det,
  output logic                     ack
);

  localparam int unsigned CntW = $clog2(3 * N);
  localparam logic [CntW-1:0] LastIdx = CntW'(3 * N - 3);

  typedef enum logic [2:0] {
    StLoad,
    StStart,
    StWait,
    StAck,
    StDrain,
    StOut
  } state_e;

  state_e               r_state;
  logic [CntW-1:0]      r_cnt;
  logic [WIDTH-1:0]     r_b [N];
  logic [WIDTH-1:0]     r_a [N-1];
  logic [WIDTH-1:0]     r_c [N-1];
  logic [2*WIDTH-1:0]   r_det;
  logic                 r_start;
  logic                 r_ack;
  logic                 r_out_valid;

  logic                 w_load;
  logic                 w_accept;

  assign w_load   = (r_state == StLoad);
  // flush wins over a coincident word, which is dropped
  assign w_accept = w_load && in_valid && !flush;

  assign in_ready  = w_load;
  assign busy      = !w_load;
  assign start     = r_start;
  assign ack       = r_ack;
  assign out_valid = r_out_valid;
  assign out_det   = r_det;

  // Pack coefficient registers onto the flat buses, index 0 at the LSBs.
  for (genvar g = 0; g < N; g++) begin : g_pack_b
    assign b_flat[g*WIDTH +: WIDTH] = r_b[g];
  end
  for (genvar g = 0; g < N - 1; g++) begin : g_pack_ac
    assign a_flat[g*WIDTH +: WIDTH] = r_a[g];
    assign c_flat[g*WIDTH +: WIDTH] = r_c[g];
  end

  // Coefficient storage: word k goes to b[k], a[k-N] or c[k-2N+1].
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_b[i] <= '0;
      end
      for (int i = 0; i < N - 1; i++) begin
        r_a[i] <= '0;
        r_c[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < N; i++) begin
        if (r_cnt == CntW'(i)) begin
          r_b[i] <= in_data;
        end
      end
      for (int i = 0; i < N - 1; i++) begin
        if (r_cnt == CntW'(N + i)) begin
          r_a[i] <= in_data;
        end
        if (r_cnt == CntW'(2 * N - 1 + i)) begin
          r_c[i] <= in_data;
        end
      end
    end
  end

  // Sequencer FSM with registered start/ack/out_valid and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StLoad;
      r_cnt       <= '0;
      r_det       <= '0;
      r_start     <= 1'b0;
      r_ack       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_ack   <= 1'b0;
      unique case (r_state)
        StLoad: begin
          if (flush) begin
            r_cnt <= '0;
          end else if (in_valid) begin
            if (r_cnt == LastIdx) begin
              r_cnt   <= '0;
              r_start <= 1'b1;
              r_state <= StStart;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StStart: begin
          r_state <= StWait;
        end
        StWait: begin
          if (done) begin
            r_det   <= det;
            r_ack   <= 1'b1;
            r_state <= StAck;
          end
        end
        StAck: begin
          r_state <= StDrain;
        end
        StDrain: begin
          // done lingers one cycle past ack; wait it out so it is not reused
          if (!done) begin
            r_out_valid <= 1'b1;
            r_state     <= StOut;
          end
        end
        StOut: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StLoad;
          end
        end
        default: begin
          r_state <= StLoad;
        end
      endcase
    end
  end

endmodule

// File: doc/tridiag_det_feeder.md
Name: tridiag_det_feeder

Overview:
- Upstream feeder and sequencer for the tridiagonal determinant unit.
- Accepts matrix coefficients one word at a time over a valid/ready stream and assembles them into the flattened a/b/c buses the determinant unit reads.
- Issues the start pulse, waits for done, captures det, returns ack, then presents the 2*WIDTH-bit result on a valid/ready output stream.
- Sits between the host/MMIO write path and the determinant unit.

Parameters:
- N, 16: matrix order, 3 <= N <= 16; must equal the determinant unit's N.
- WIDTH, 16: coefficient width in bits, <= 16; must equal the determinant unit's WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  coefficient word valid.
- in_ready  out  1  feeder accepts a word this cycle.
- in_data  in  WIDTH  coefficient word, two's complement.
- flush  in  1  discard a partially loaded matrix; honoured only in LOAD.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_det  out  2*WIDTH  signed determinant result.
- busy  out  1  high in every state except LOAD.
- a_flat  out  WIDTH*(N-1)  to determinant unit; a[0] at LSBs.
- b_flat  out  WIDTH*N  to determinant unit; b[0] at LSBs.
- c_flat  out  WIDTH*(N-1)  to determinant unit; c[0] at LSBs.
- start  out  1  to determinant unit; one-cycle pulse.
- done  in  1  from determinant unit; held high until ack is seen.
- det  in  2*WIDTH  from determinant unit; valid while done=1.
- ack  out  1  to determinant unit; one-cycle pulse.

Behaviour:
- Reset, synchronous and active-high:
  - state=LOAD, cnt=0.
  - a_flat, b_flat, c_flat, out_det = 0.
  - start, ack, out_valid = 0; busy=0.
  - Reset mid-operation abandons any transfer. The determinant unit shares rst, so both return to idle together.
- States: LOAD, START, WAIT, ACK, DRAIN, OUT. All outputs are registered except in_ready and busy, which decode from state.
- LOAD:
  - in_ready=1.
  - A word is accepted on in_valid & in_ready.
  - Word order and storage for word index k, with cnt of width $clog2(3N):
    - k < N: stored to b[k].
    - N <= k < 2N-1: stored to a[k-N].
    - 2N-1 <= k < 3N-2: stored to c[k-2N+1].
  - cnt increments per accepted word.
  - Accepting word 3N-3 sets cnt=0 and moves to START.
  - flush=1 sets cnt=0 and leaves already-written slots unchanged. It has priority over a simultaneous word: that word is dropped and in_ready is still high.
  - Flats are never cleared between matrices; every slot is rewritten each load.
- START: start=1 for exactly one cycle, then WAIT. in_ready=0 from here until return to LOAD.
- WAIT:
  - The flats are held stable; the determinant unit reads them over N-2 CALC cycles.
  - On done=1, capture out_det <= det and go to ACK.
  - No timeout.
- ACK:
  - ack=1 for exactly one cycle, then DRAIN.
  - The determinant unit returns to idle on the ack edge and drops done one cycle later.
- DRAIN: wait for done=0. This prevents a stale done from being sampled for the next matrix. Then go to OUT.
- OUT:
  - out_valid=1; out_det stable.
  - On out_valid & out_ready: out_valid <= 0, go to LOAD.
  - out_ready high on the first OUT cycle gives a one-cycle OUT.
- Latency: start issued 1 cycle after the last word; end-to-end latency is set by the determinant unit plus 3 cycles (ACK, DRAIN, OUT entry).
- Throughput: one matrix at a time; no new words are accepted until the result is consumed.
- Arithmetic: none in the feeder; in_data is copied bit-exact, and the sign is interpreted downstream.

Test Plan:
- Reset check: rst for 2 cycles -> all flats 0, start=ack=out_valid=0, in_ready=1, busy=0.
- Defaults with the determinant unit attached, b[i]=2, a[i]=c[i]=1, 46 words with continuous in_valid:
  - start pulses once, 1 cycle after word 45.
  - out_det=17 (N+1).
  - ack is exactly one cycle wide.
- Identity matrix (b=1, a=c=0), out_ready held low for 10 cycles:
  - out_valid stays high with out_det=1 and in_ready=0.
  - Then one out_ready cycle returns the block to LOAD.
- Signed data: b[i]=16'hFFFF (-1), a=c=0 -> out_det=32'h00000001. b[0]=16'hFFFE, rest 1, a=c=0 -> out_det=32'hFFFFFFFE.
- Flush after 20 words, then a full 46-word load of the second test's matrix -> out_det=17, with no start issued before the flush.
- Back-to-back matrices with gaps on in_valid, plus rst asserted during WAIT:
  - No spurious start.
  - The second result is correct.
  - After the mid-run reset, a fresh load yields the correct det.
